// File: rtl/fmul_iter.sv
// Iterative binary32 multiplier: shift-add mantissa engine (MUL_BITS per clock) plus one normalize/round cycle.
// Define FMUL_ROUND_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
module fmul_iter #(
   parameter int FP_DW    = 32,
   parameter int MUL_BITS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mul_op_en,
   input  logic [FP_DW-1:0] mul_rb,
   input  logic [FP_DW-1:0] mul_rc,
   output logic [FP_DW-1:0] mul_ra,
   output logic             mul_busy,
   output logic             mul_done,
   output logic             mul_ovf_flag,
   output logic             mul_unf_flag
);
   localparam int         K    = 24 / MUL_BITS;
   localparam logic [4:0] LAST = 5'(K - 1);
   localparam logic [4:0] MB5  = 5'(MUL_BITS);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM} state_t;
   state_t state_q, state_d;

   logic               sign_q, sign_d, zero_q, zero_d;
   logic signed [9:0]  exp_q, exp_d;
   logic [23:0]        mcand_q, mcand_d, mplier_q, mplier_d;
   logic [47:0]        acc_q, acc_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [FP_DW-1:0]   ra_q, ra_d;
   logic               ovf_q, ovf_d, unf_q, unf_d, done_q, done_d;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (mul_op_en) state_d = S_MUL;
         S_MUL:   if (cnt_q == LAST) state_d = S_NORM;
         S_NORM:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      mul_busy = (state_q == S_MUL) || (state_q == S_NORM);
   end

   // Partial product of one multiplier digit, placed at its weight
   logic [47:0] pp;
   logic [4:0]  shamt;
   always_comb begin
      pp    = 48'(mcand_q) * 48'(mplier_q[MUL_BITS-1:0]);
      shamt = cnt_q * MB5;
   end

   // Normalize and round the finished product
   logic              hi, rnd_inc;
   logic [22:0]       man_t;
   logic [23:0]       man_r;
   logic signed [9:0] exp_f;
   logic              guard, sticky;
   always_comb begin
      hi     = acc_q[47];
      man_t  = hi ? acc_q[46:24] : acc_q[45:23];
      guard  = hi ? acc_q[23] : acc_q[22];
      sticky = hi ? (|acc_q[22:0]) : (|acc_q[21:0]);
`ifdef FMUL_ROUND_RNE_EN
      rnd_inc = guard & (sticky | man_t[0]);
`else
      rnd_inc = 1'b0;
`endif
      man_r = {1'b0, man_t} + {23'b0, rnd_inc};
      exp_f = exp_q + $signed({9'b0, hi}) + $signed({9'b0, man_r[23]});
   end
`ifndef FMUL_ROUND_RNE_EN
   logic unused_rnd;
   assign unused_rnd = guard ^ sticky;
`endif

   always_comb begin
      sign_d   = sign_q;
      zero_d   = zero_q;
      exp_d    = exp_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      ra_d     = ra_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: if (mul_op_en) begin
            sign_d   = mul_rb[31] ^ mul_rc[31];
            exp_d    = $signed({2'b0, mul_rb[30:23]}) + $signed({2'b0, mul_rc[30:23]}) - 10'sd127;
            zero_d   = (mul_rb[30:23] == 8'd0) || (mul_rc[30:23] == 8'd0);
            mcand_d  = {1'b1, mul_rb[22:0]};
            mplier_d = {1'b1, mul_rc[22:0]};
            acc_d    = '0;
            cnt_d    = '0;
         end
         S_MUL: begin
            acc_d    = acc_q + (pp << shamt);
            mplier_d = mplier_q >> MUL_BITS;
            cnt_d    = cnt_q + 5'd1;
         end
         S_NORM: begin
            done_d = 1'b1;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
            if (zero_q) begin
               ra_d = {sign_q, 31'b0};
            end else if (exp_f >= 10'sd255) begin
               ra_d  = {sign_q, 8'hFF, 23'b0};
               ovf_d = 1'b1;
            end else if (exp_f <= 10'sd0) begin
               ra_d  = {sign_q, 31'b0};
               unf_d = 1'b1;
            end else begin
               ra_d = {sign_q, exp_f[7:0], man_r[22:0]};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q   <= 1'b0;
         zero_q   <= 1'b0;
         exp_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         ra_q     <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         sign_q   <= sign_d;
         zero_q   <= zero_d;
         exp_q    <= exp_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         ra_q     <= ra_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         done_q   <= done_d;
      end
   end

   assign mul_ra       = ra_q;
   assign mul_done     = done_q;
   assign mul_ovf_flag = ovf_q;
   assign mul_unf_flag = unf_q;
endmodule

// File: tb/tb_fmul_iter.sv
// Scoreboard bench for fmul_iter: driver queues expected results, a negedge monitor checks each mul_done.
module tb_fmul_iter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mul_op_en = 1'b0;
   logic [31:0] mul_rb = '0, mul_rc = '0;
   logic [31:0] mul_ra;
   logic        mul_busy, mul_done, mul_ovf_flag, mul_unf_flag;

   fmul_iter #(.FP_DW(32), .MUL_BITS(2)) dut (
      .clk(clk), .rst(rst), .mul_op_en(mul_op_en), .mul_rb(mul_rb), .mul_rc(mul_rc),
      .mul_ra(mul_ra), .mul_busy(mul_busy), .mul_done(mul_done),
      .mul_ovf_flag(mul_ovf_flag), .mul_unf_flag(mul_unf_flag)
   );

   always #5 clk = ~clk;

`ifdef FMUL_ROUND_RNE_EN
   localparam logic [31:0] RND_EXP = 32'h40100002;
`else
   localparam logic [31:0] RND_EXP = 32'h40100001;
`endif
   localparam int LAT = 13;

   typedef struct {
      logic [31:0] ra;
      logic        ovf;
      logic        unf;
      int          st;
   } exp_t;
   exp_t q[$];

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (mul_done === 1'b1) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: done at cycle %0d with no operation outstanding", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("result", mul_ra, e.ra);
            chk("ovf_flag", {31'b0, mul_ovf_flag}, {31'b0, e.ovf});
            chk("unf_flag", {31'b0, mul_unf_flag}, {31'b0, e.unf});
            chk("latency", 32'(cyc - e.st), 32'(LAT));
         end
      end
   end

   task automatic issue(input logic [31:0] b, input logic [31:0] c, input logic [31:0] ra,
                        input logic ovf, input logic unf, input bit push);
      @(posedge clk); #1;
      mul_op_en = 1'b1; mul_rb = b; mul_rc = c;
      @(posedge clk); #1;
      mul_op_en = 1'b0;
      if (push) q.push_back('{ra, ovf, unf, cyc});
   endtask

   task automatic idle_wait();
      repeat (16) @(posedge clk);
   endtask

   initial begin
      int nb;
      int st0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ra", mul_ra, 32'h0);
      chk("rst_busy", {31'b0, mul_busy}, 32'h0);
      chk("rst_done", {31'b0, mul_done}, 32'h0);
      chk("rst_flags", {30'b0, mul_ovf_flag, mul_unf_flag}, 32'h0);

      // 1.5 x 2, with busy-window measurement
      issue(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b1);
      nb = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (mul_busy) nb++;
      end
      chk("busy_cycles", 32'(nb), 32'd13);

      issue(32'h80000000, 32'h40490FDB, 32'h80000000, 1'b0, 1'b0, 1'b1); idle_wait();
      issue(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, 1'b1); idle_wait();
      issue(32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1, 1'b1); idle_wait();
      issue(32'h3FC00001, 32'h3FC00001, RND_EXP,      1'b0, 1'b0, 1'b1); idle_wait();
      issue(32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0, 1'b1); idle_wait();

      // Abort mid-operation; a start presented together with rst must be dropped
      issue(32'h3FC00000, 32'h40000000, 32'h0, 1'b0, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1; mul_op_en = 1'b1;
      @(posedge clk); #1 rst = 1'b0; mul_op_en = 1'b0;
      @(negedge clk);
      chk("abort_ra", mul_ra, 32'h0);
      chk("abort_busy", {31'b0, mul_busy}, 32'h0);
      chk("abort_flags", {30'b0, mul_ovf_flag, mul_unf_flag}, 32'h0);
      issue(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b1); idle_wait();

      // Start pulse while busy is ignored
      issue(32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1 mul_op_en = 1'b1; mul_rb = 32'h3F800000; mul_rc = 32'h3F800000;
      @(posedge clk); #1 mul_op_en = 1'b0;
      idle_wait();

      // Held start: three operations at a 14-cycle period
      @(posedge clk); #1;
      mul_op_en = 1'b1; mul_rb = 32'h3FC00000; mul_rc = 32'h40000000;
      @(posedge clk); #1;
      st0 = cyc;
      for (int k = 0; k < 3; k++) q.push_back('{32'h40400000, 1'b0, 1'b0, st0 + 14 * k});
      repeat (28) @(posedge clk);
      #1 mul_op_en = 1'b0;

      for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
      repeat (20) @(posedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fmul_iter.md
# fmul_iter

Iterative single-precision floating-point multiplier. It is the inverse-direction companion to the combinational Goldschmidt divider in the transcendental-function datapath: it reconstructs dividends from quotients and scales iteration results. Operation is started by a one-cycle `mul_op_en` strobe. Mantissas are multiplied by a shift-add engine that retires `MUL_BITS` multiplier bits per clock, followed by one normalize/round cycle. The result is returned with a done pulse and overflow/underflow flags.

## Interface
- `FP_DW`, 32 — operand/result width; IEEE-754 binary32 layout only.
- `MUL_BITS`, 2 — multiplier bits retired per MUL cycle; legal values 1, 2, 4, 8. K = 24/MUL_BITS iterations.
- `clk` in 1 — clock; all state changes on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `mul_op_en` in 1 — start strobe; sampled only in IDLE.
- `mul_rb` in FP_DW — operand B; captured when the start is accepted.
- `mul_rc` in FP_DW — operand C; captured when the start is accepted.
- `mul_ra` out FP_DW — product; valid from the `mul_done` cycle, held until the next `mul_done`.
- `mul_busy` out 1 — high in MUL and NORM.
- `mul_done` out 1 — one-cycle pulse; result and flags valid.
- `mul_ovf_flag` out 1 — product saturated to ±inf; updated with `mul_done`.
- `mul_unf_flag` out 1 — product flushed to ±0; updated with `mul_done`.

## Operation
- States: IDLE, MUL, NORM.
- **IDLE**
  - `mul_op_en`=1: latch sign = rb[31]^rc[31] and the 10-bit signed exponent sum rb[30:23]+rc[30:23]-127.
  - Load mantissas {1,rb[22:0]} and {1,rc[22:0]}; clear the 48-bit accumulator; clear the iteration counter; go to MUL.
  - If either exponent field is 0, set the zero flag; the iterations still run, so latency is constant.
- **MUL**
  - Each cycle: accumulator += (multiplicand × low MUL_BITS of multiplier) << (counter·MUL_BITS).
  - Shift the multiplier right by MUL_BITS; increment the counter.
  - After K cycles go to NORM.
- **NORM** (1 cycle)
  - If P[47]=1: take mantissa P[46:24] and increment the exponent. Otherwise take P[45:23].
  - Guard = next lower bit; sticky = OR of the remaining bits.
  - Apply rounding (see Configuration). A round carry-out renormalizes the mantissa to 0 and increments the exponent.
  - Zero flag set: `mul_ra` = {sign, 31'b0}; no flags raised.
  - Exponent ≥ 255: `mul_ra` = {sign, 8'hFF, 23'b0}; `mul_ovf_flag`=1.
  - Exponent ≤ 0: `mul_ra` = {sign, 31'b0}; `mul_unf_flag`=1. Subnormals are never produced.
  - Otherwise: `mul_ra` = {sign, exp[7:0], mantissa}; both flags 0.
  - Pulse `mul_done`; go to IDLE.
- Inf/NaN inputs (exponent field 255) are not special-cased; they are treated as ordinary exponents.
- `mul_op_en` during MUL or NORM is ignored; no queueing.

## Timing
- Reset values: state IDLE; `mul_ra`=0; `mul_busy`=0; `mul_done`=0; both flags 0; accumulator and counter 0.
- Start sampled at edge 0. MUL occupies edges 1..K. `mul_done` is high during the cycle after edge K+1. Default: 13 cycles after the start edge.
- Throughput: one operation per K+2 cycles. With `mul_op_en` held high, a new start is accepted on the edge ending the `mul_done` cycle.
- `rst` asserted mid-operation:
  - Aborts the operation; state returns to IDLE.
  - All outputs return to reset values on that edge; no `mul_done` is issued.
  - A `mul_op_en` in the same cycle as `rst` is dropped.

## Configuration
- `FMUL_ROUND_RNE_EN` defined: round-to-nearest-even. Increment when guard & (sticky | mantissa LSB).
- Not defined: truncation; guard and sticky are ignored. This matches the divider's truncating output.

## Test plan
- 0x3FC00000 × 0x40000000 (1.5×2) → `mul_ra`=0x40400000, `mul_done` exactly 13 cycles after the start, flags 0, `mul_busy` high for 13 cycles.
- 0x80000000 × 0x40490FDB → 0x80000000, no flags.
- 0x7F000000 × 0x40000000 → 0x7F800000, `mul_ovf_flag`=1.
- 0x00800000 × 0x3F000000 → 0x00000000, `mul_unf_flag`=1.
- 0x3FC00001 × 0x3FC00001 → 0x40100002 with `FMUL_ROUND_RNE_EN`, 0x40100001 without.
- `rst` pulsed at cycle 5 of an operation, then a new start of 0x3F800000 × 0x3F800000 → no `mul_done` for the aborted operation; 0x3F800000 13 cycles after the new start.
- Back-to-back: `mul_op_en` held high → `mul_done` every 14 cycles; `mul_op_en` pulsed while busy is ignored.
